// File: rtl/two_bit_counter_table_pkg.sv
// Shared branch-predictor types: 2-bit direction counter encoding and table geometry.
package bp_pkg;
  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  localparam ctr_t INIT_STATE  = WNT;
  localparam int   INDEX_W     = 8;
  localparam int   NUM_ENTRIES = 1 << INDEX_W;

  // Upper half of the encoding predicts taken.
  function automatic logic ctr_taken(ctr_t c);
    return c >= WT;
  endfunction
endpackage

// File: rtl/two_bit_counter_table_if.sv
// Fetch/decode/execute side of the counter table: read, entry reset and training.
interface two_bit_counter_table_if #(
  parameter int INDEX_W = 8
);
  logic               feedback;
  logic               get;
  logic [INDEX_W-1:0] get_index;
  logic               set;
  logic [INDEX_W-1:0] set_index;
  logic               reset;
  logic [INDEX_W-1:0] reset_index;
  logic               prediction;

  modport master (
    output feedback, get, get_index, set, set_index, reset, reset_index,
    input  prediction
  );

  modport slave (
    input  feedback, get, get_index, set, set_index, reset, reset_index,
    output prediction
  );
endinterface

// File: rtl/two_bit_counter_table_sat_counter2.sv
// One 2-bit saturating direction counter; load_init overrides training.
module sat_counter2 import bp_pkg::*; #(
  parameter ctr_t INIT = bp_pkg::INIT_STATE
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic load_init,
  output ctr_t state
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      state <= INIT;
    else if (load_init)           state <= INIT;
    else if (inc && state != ST)  state <= state + 2'd1;
    else if (dec && state != SNT) state <= state - 2'd1;
  end
endmodule

// File: rtl/two_bit_counter_table.sv
// Table of independent 2-bit branch-direction counters with a zero-cycle read port.
module two_bit_counter_table import bp_pkg::*; #(
  parameter int   NUM_ENTRIES = bp_pkg::NUM_ENTRIES,
  parameter int   INDEX_W     = bp_pkg::INDEX_W,
  parameter ctr_t INIT_STATE  = bp_pkg::INIT_STATE
) (
  input logic clk,
  input logic rst,
  two_bit_counter_table_if.slave bus
);
  ctr_t ctr [NUM_ENTRIES];

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ent
    localparam logic [INDEX_W-1:0] IDX = INDEX_W'(i);
    logic hit_set, hit_rst;

    assign hit_set = bus.set && (bus.set_index == IDX);
    assign hit_rst = bus.reset && (bus.reset_index == IDX);

    sat_counter2 #(.INIT(INIT_STATE)) u_ctr (
      .clk       (clk),
      .rst       (rst),
      .inc       (hit_set && bus.feedback),
      .dec       (hit_set && !bus.feedback),
      .load_init (hit_rst),
      .state     (ctr[i])
    );
  end

  // No write bypass: a same-cycle write shows up only after the edge.
  assign bus.prediction = bus.get && ctr_taken(ctr[bus.get_index]);
endmodule

// File: tb/tb_two_bit_counter_table.sv
// Directed bench for the counter table with a per-cycle reference model.
module tb_two_bit_counter_table;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   model [256];

  two_bit_counter_table_if #(.INDEX_W(8)) bus ();

  two_bit_counter_table dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: counters as plain integers clamped to 0..3; a reset of an entry beats its training.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) model[k] = 1;
    end else begin
      if (bus.set) begin
        if (bus.feedback) model[bus.set_index] = (model[bus.set_index] == 3) ? 3 : model[bus.set_index] + 1;
        else              model[bus.set_index] = (model[bus.set_index] == 0) ? 0 : model[bus.set_index] - 1;
      end
      if (bus.reset) model[bus.reset_index] = 1;
    end
  end

  always @(negedge clk) begin
    logic exp_p;
    exp_p = bus.get && (model[bus.get_index] >= 2);
    checks++;
    if (bus.prediction !== exp_p) begin
      errors++;
      $display("FAIL model_cmp t=%0t idx=%0d got=%b exp=%b", $time, bus.get_index, bus.prediction, exp_p);
    end
  end

  task automatic chk(input string name, input logic exp_p);
    checks++;
    if (bus.prediction !== exp_p) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, bus.prediction, exp_p);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic train(input int idx, input logic fb);
    bus.set = 1'b1; bus.set_index = 8'(idx); bus.feedback = fb;
    cyc();
    bus.set = 1'b0;
  endtask

  task automatic rd(input string name, input int idx, input logic exp_p);
    bus.get = 1'b1; bus.get_index = 8'(idx);
    #1;
    chk(name, exp_p);
  endtask

  initial begin
    rst = 1'b1;
    bus.feedback = 1'b0; bus.get = 1'b0; bus.get_index = '0;
    bus.set = 1'b0; bus.set_index = '0; bus.reset = 1'b0; bus.reset_index = '0;
    #3;
    rd("rst_idx0", 0, 1'b0);
    @(negedge clk); rst = 1'b0;
    cyc();
    rd("init_idx0", 0, 1'b0);
    rd("init_idx17", 17, 1'b0);
    rd("init_idx255", 255, 1'b0);
    bus.get = 1'b0; #1 chk("get_low", 1'b0);

    // Index 5: WNT -> WT -> ST (saturate) -> WT -> WNT
    train(5, 1); rd("i5_wt", 5, 1'b1);
    train(5, 1); train(5, 1); rd("i5_st", 5, 1'b1);
    train(5, 0); rd("i5_back_wt", 5, 1'b1);
    train(5, 0); rd("i5_wnt", 5, 1'b0);

    // Index 9: down to SNT and saturate, then climb back
    train(9, 0); train(9, 0); train(9, 0); rd("i9_snt", 9, 1'b0);
    train(9, 1); rd("i9_wnt", 9, 1'b0);
    train(9, 1); rd("i9_wt", 9, 1'b1);

    // Index 3: entry reset alone, then reset colliding with training
    train(3, 1); train(3, 1); rd("i3_st", 3, 1'b1);
    bus.reset = 1'b1; bus.reset_index = 8'd3; cyc(); bus.reset = 1'b0;
    rd("i3_reset", 3, 1'b0);
    train(3, 1); train(3, 1); rd("i3_st2", 3, 1'b1);
    bus.reset = 1'b1; bus.reset_index = 8'd3;
    bus.set = 1'b1; bus.set_index = 8'd3; bus.feedback = 1'b1;
    cyc(); bus.reset = 1'b0; bus.set = 1'b0;
    rd("i3_reset_wins", 3, 1'b0);
    train(3, 0); rd("i3_was_wnt", 3, 1'b0);

    // Read and train index 7 in the same cycle: pre-write value first
    bus.get = 1'b1; bus.get_index = 8'd7;
    bus.set = 1'b1; bus.set_index = 8'd7; bus.feedback = 1'b1;
    #1 chk("i7_no_bypass", 1'b0);
    cyc(); bus.set = 1'b0;
    chk("i7_after", 1'b1);
    rd("i8_untouched", 8, 1'b0);

    // Different indices in one cycle: both take effect
    train(21, 1); train(21, 1);
    bus.set = 1'b1; bus.set_index = 8'd20; bus.feedback = 1'b1;
    bus.reset = 1'b1; bus.reset_index = 8'd21;
    cyc(); bus.set = 1'b0; bus.reset = 1'b0;
    rd("i20_trained", 20, 1'b1);
    rd("i21_reset", 21, 1'b0);

    // Asynchronous rst between edges wipes history; rst dominates a pending train
    train(10, 1); train(10, 1); train(200, 1); train(200, 1);
    rd("i10_st", 10, 1'b1);
    rst = 1'b1;
    #1 chk("async_rst_drop", 1'b0);
    bus.set = 1'b1; bus.set_index = 8'd10; bus.feedback = 1'b1;
    cyc();
    chk("rst_dominates", 1'b0);
    @(negedge clk); rst = 1'b0; bus.set = 1'b0;
    cyc();
    rd("i10_after_rst", 10, 1'b0);
    rd("i200_after_rst", 200, 1'b0);
    rd("i5_after_rst", 5, 1'b0);
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
